// File: rtl/id_pkg.sv
// Shared opcode constants and decode helpers for the ID stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_NOP_CODE = 6'h3F;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

  // Opcodes that read rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_SB) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file; r0 hardwired to zero, write-through bypass.
module regfile_bypass #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wnum,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rnum_a,
  input  logic [AW-1:0]     rnum_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_en;

  assign wr_en = we && (wnum != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wnum] <= wdata;
    end
  end

  // Same-cycle writeback is forwarded so ID never sees a stale operand.
  always_comb begin
    rdata_a = mem[rnum_a];
    rdata_b = mem[rnum_b];
    if (wr_en && (wnum == rnum_a)) rdata_a = wdata;
    if (wr_en && (wnum == rnum_b)) rdata_b = wdata;
    if (rnum_a == '0) rdata_a = '0;
    if (rnum_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered, stallable MIPS instruction-decode stage with load-use interlock.
// Optional macro ID_STALL_COUNTER_EN adds a saturating stall_count output.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_num,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rd_num,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_func,
  output logic [4:0]        out_shamt,
  output logic [25:0]       out_jea,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_is_nop
`ifdef ID_STALL_COUNTER_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  logic [5:0]        opcode_raw;
  logic [5:0]        dec_opcode;
  logic              inst_nop;
  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] dec_rd;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              hazard;
  logic              free;
  logic              load;

  assign opcode_raw = in_inst[31:26];
  assign inst_nop   = (in_inst == 32'h0);
  assign dec_opcode = inst_nop ? OP_NOP_CODE : opcode_raw;
  assign rs_idx     = in_inst[21 +: REG_AW];
  assign rt_idx     = in_inst[16 +: REG_AW];

  regfile_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst_b),
    .we      (wb_we),
    .wnum    (wb_num),
    .wdata   (wb_data),
    .rnum_a  (rs_idx),
    .rnum_b  (rt_idx),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  // Destination register and immediate extension.
  always_comb begin
    dec_rd = rt_idx;
    if (dec_opcode == OP_RTYPE)   dec_rd = in_inst[11 +: REG_AW];
    else if (dec_opcode == OP_JAL) dec_rd = REG_AW'(NUM_REGS - 1);
    dec_imm = is_zero_ext(opcode_raw) ? DATA_W'(in_inst[15:0])
                                      : DATA_W'($signed(in_inst[15:0]));
  end

  assign hazard = in_valid && !inst_nop && ex_is_load && (ex_rd_num != '0) &&
                  ((ex_rd_num == rs_idx) || (uses_rt(opcode_raw) && (ex_rd_num == rt_idx)));

  assign free     = !out_valid || out_ready;
  assign in_ready = free && !hazard && !flush;
  assign load     = in_valid && in_ready;

  // ID/EX register: flush squashes, free-without-load inserts a bubble, !free holds.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_rd_num  <= '0;
      out_opcode  <= '0;
      out_func    <= '0;
      out_shamt   <= '0;
      out_jea     <= '0;
      out_pc      <= '0;
      out_is_nop  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_rs_data <= rs_data;
      out_rt_data <= rt_data;
      out_imm     <= dec_imm;
      out_rd_num  <= dec_rd;
      out_opcode  <= dec_opcode;
      out_func    <= in_inst[5:0];
      out_shamt   <= in_inst[10:6];
      out_jea     <= in_inst[25:0];
      out_pc      <= in_pc;
      out_is_nop  <= inst_nop;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ID_STALL_COUNTER_EN
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && !flush && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the pipelined MIPS core, between the IF/ID register and EX.
- Contains a multi-entry register file with write-through bypass, immediate extension, destination selection, load-use interlock and an ID/EX output register with valid/ready handshake and flush.
- Replaces the combinational decode path with a registered, stallable stage.

Parameters:
- DATA_W, 32, register and immediate width (>=16).
- NUM_REGS, 32, register-file entries (power of two, >=2).
- REG_AW, $clog2(NUM_REGS), register index width (derived; do not override).
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous reset, active-high. Despite the name, asserted = 1.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts in_inst this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  ADDR_W  instruction address.
- wb_we  in  1  writeback enable.
- wb_num  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_is_load  in  1  instruction currently in EX is a load.
- ex_rd_num  in  REG_AW  destination of the EX instruction.
- flush  in  1  squash the stage (taken branch/jump).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the ID/EX contents.
- out_rs_data, out_rt_data  out  DATA_W  operand values.
- out_imm  out  DATA_W  extended immediate.
- out_rd_num  out  REG_AW  destination register.
- out_opcode  out  6  inst[31:26] (6'h3F for an all-zero word).
- out_func  out  6  inst[5:0].
- out_shamt  out  5  inst[10:6].
- out_jea  out  26  inst[25:0].
- out_pc  out  ADDR_W  pc of the registered instruction.
- out_is_nop  out  1  registered instruction was 32'h0.

Behaviour:
- Reset: while rst_b=1, all registers clear asynchronously.
  - Every out_* port reads 0 except out_opcode, which reads 0.
  - All register-file entries read 0.
  - in_ready reads 1 once reset is released.
- Register file:
  - Reads are combinational; writes occur on the clk edge when wb_we=1.
  - Register 0 always reads 0; writes to it are ignored.
  - Bypass: if wb_we=1, wb_num!=0 and wb_num equals the read index, the read returns wb_data in the same cycle.
- Indices: rs = inst[25:21], rt = inst[20:16]. For NUM_REGS<32, use the low REG_AW bits.
- Destination:
  - opcode 0 (R-type): inst[15:11].
  - opcode 0x03 (JAL): NUM_REGS-1.
  - All other opcodes: rt.
- Immediate: zero-extended for opcodes 0x0C, 0x0D, 0x0E; otherwise sign-extended from inst[15:0] to DATA_W.
- uses_rt = opcode 0, 0x04, 0x05, 0x28 or 0x2B.
- hazard = in_valid & ex_is_load & ex_rd_num!=0 & (ex_rd_num==rs | (uses_rt & ex_rd_num==rt)). An all-zero instruction never raises hazard.
- Handshake:
  - free = !out_valid | out_ready.
  - in_ready = free & !hazard & !flush.
  - Load the output register when in_valid & in_ready.
  - If free but no load occurs, set out_valid <= 0 (bubble).
  - If !free, hold all out_* values.
- Flush has priority over everything: out_valid <= 0 next edge; in_ready=0 that cycle; register-file writes still occur.
- Simultaneous flush and hazard: flush wins.
- Simultaneous writeback and load of the same register: the loaded operand carries wb_data via the bypass.
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready=1 and no hazard.

Optional Feature:
- Macro: ID_STALL_COUNTER_EN.
- With the macro defined:
  - Adds output stall_count (32 bits), reset to 0.
  - Increments on each cycle with in_valid & !in_ready & !flush.
  - Saturates at 32'hFFFFFFFF.
- Without the macro: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package id_pkg holds:
  - opcode localparams OP_RTYPE, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_SB, OP_SW, OP_NOP_CODE (6'h3F);
  - function is_zero_ext(opcode);
  - function uses_rt(opcode).
- One sub-module, regfile_bypass (parameters DATA_W, NUM_REGS): two read ports, one write port, register-0 hardwire and write-through bypass.
- Decode, hazard logic and the pipeline register stay in id_stage_pipe.

Test Plan:
- Reset with outputs dirty -> all out_* are 0 and out_valid=0 while rst_b=1; after release, in_ready=1.
- Write r5=32'hDEADBEEF, then in the same cycle present ADD r3,r5,r0 -> next cycle out_rs_data=32'hDEADBEEF, out_rd_num=3, out_valid=1.
- ex_is_load=1, ex_rd_num=5, in_inst=ADDI r6,r5,-1 -> in_ready=0 for that cycle and out_valid=0 next. With ex_is_load=0, out_imm=32'hFFFFFFFF.
- ORI r2,r1,16'h8000 -> out_imm=32'h00008000. JAL -> out_rd_num=31. Inst 0 -> out_is_nop=1, out_opcode=6'h3F, no stall.
- out_ready=0 for 3 cycles with a stream of valid inputs -> in_ready=0 and out_* stable. Then assert flush -> out_valid=0 next cycle. Then out_ready=1 -> one accept per cycle.
- Write to r0 with 32'h1234, then read r0 -> 0. NUM_REGS=16 build: JAL -> out_rd_num=15.
